// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times the start-bit low pulse of a 0x55 sync character and drives a 3-bit rate code.
// Optional macro AUTOBAUD_VERIFY_EN adds a second measurement of the following high pulse as a cross-check.
module uart_autobaud_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int IDLE_CYCLES = 1024,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    input  logic               start,
    input  logic               abort,
    output logic [2:0]         baud_sel,
    output logic               locked,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] meas_cnt
);

    localparam int P0      = CLK_HZ / 9600;
    localparam int P1      = CLK_HZ / 19200;
    localparam int P2      = CLK_HZ / 38400;
    localparam int P3      = CLK_HZ / 57600;
    localparam int P4      = CLK_HZ / 115200;
    localparam int T01     = (P0 + P1) / 2;
    localparam int T12     = (P1 + P2) / 2;
    localparam int T23     = (P2 + P3) / 2;
    localparam int T34     = (P3 + P4) / 2;
    localparam int MIN_CNT = P4 / 2;
    localparam int MAX_CNT = P0 + P0 / 2;

    localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_CNT);
    localparam logic [COUNT_W-1:0] SAT_C  = COUNT_W'(MAX_CNT + 1);
    localparam logic [COUNT_W-1:0] IDLE_C = COUNT_W'(IDLE_CYCLES);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_IDLE = 3'd1;
    localparam logic [2:0] S_ARMED     = 3'd2;
    localparam logic [2:0] S_MEAS_LOW  = 3'd3;
`ifdef AUTOBAUD_VERIFY_EN
    localparam logic [2:0] S_MEAS_HIGH = 3'd4;
`endif

    // Pulse counter stops at MAX_CNT+1 so an overlong pulse can never wrap into a valid range.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v >= SAT_C) ? SAT_C : v + 1'b1;
    endfunction

    // Returns {valid, code}; midpoints between neighbouring bit periods split the rates.
    function automatic logic [3:0] classify(input logic [COUNT_W-1:0] v);
        if (v > MAX_C)                     return 4'b0_000;
        else if (v >= COUNT_W'(T01))       return 4'b1_000;
        else if (v >= COUNT_W'(T12))       return 4'b1_001;
        else if (v >= COUNT_W'(T23))       return 4'b1_010;
        else if (v >= COUNT_W'(T34))       return 4'b1_011;
        else if (v >= COUNT_W'(MIN_CNT))   return 4'b1_100;
        else                               return 4'b0_000;
    endfunction

    logic               rx_meta_p0;
    logic               rx_s_p1;
    logic               rx_s_p2;
    logic [2:0]         state;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_inc;
    logic [3:0]         cls;
    logic               fall;
    logic               rise;
`ifdef AUTOBAUD_VERIFY_EN
    logic [2:0]         low_code;
`endif

    // Stage p0/p1: synchroniser; stage p2: previous rx_s for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_p0 <= 1'b1;
            rx_s_p1    <= 1'b1;
            rx_s_p2    <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_s_p1    <= rx_meta_p0;
            rx_s_p2    <= rx_s_p1;
        end
    end

    assign fall    = rx_s_p2 & ~rx_s_p1;
    assign rise    = ~rx_s_p2 & rx_s_p1;
    assign cnt_inc = sat_inc(cnt);
    assign cls     = classify(cnt);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            baud_sel <= 3'b000;
            locked   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            meas_cnt <= '0;
`ifdef AUTOBAUD_VERIFY_EN
            low_code <= 3'b000;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            locked <= 1'b0;
                            err    <= 1'b0;
                            cnt    <= '0;
                            state  <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (!rx_s_p1) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt + 1'b1 == IDLE_C) state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (fall) begin
                            cnt   <= COUNT_W'(1);
                            state <= S_MEAS_LOW;
                        end
                    end
                    S_MEAS_LOW: begin
                        if (rise) begin
                            meas_cnt <= cnt;
                            if (!cls[3]) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
`ifdef AUTOBAUD_VERIFY_EN
                                low_code <= cls[2:0];
                                cnt      <= COUNT_W'(1);
                                state    <= S_MEAS_HIGH;
`else
                                baud_sel <= cls[2:0];
                                locked   <= 1'b1;
                                done     <= 1'b1;
                                state    <= S_IDLE;
`endif
                            end
                        end else if (!rx_s_p1) begin
                            cnt <= cnt_inc;
                            if (cnt_inc > MAX_C) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    end
`ifdef AUTOBAUD_VERIFY_EN
                    S_MEAS_HIGH: begin
                        if (fall) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                            if (cls[3] && cls[2:0] == low_code) begin
                                baud_sel <= low_code;
                                locked   <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (rx_s_p1) begin
                            cnt <= cnt_inc;
                            if (cnt_inc > MAX_C) begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: directed and randomized pulse widths checked against a rate-table model.
module tb_uart_autobaud_ctrl;

    localparam int CLK_HZ      = 50_000_000;
    localparam int IDLE_CYCLES = 1024;
    localparam int COUNT_W     = 16;
    localparam int IDLE_WAIT   = IDLE_CYCLES + 6;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               rx    = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [2:0]         baud_sel;
    logic               locked;
    logic               busy;
    logic               done;
    logic               err;
    logic [COUNT_W-1:0] meas_cnt;

    int checks     = 0;
    int failures   = 0;
    int done_cnt   = 0;
    int exp_baud   = 0;
    int exp_locked = 0;
    int exp_err    = 0;
    int exp_meas   = 0;

    always #5 clk = ~clk;

    uart_autobaud_ctrl #(
        .CLK_HZ(CLK_HZ),
        .IDLE_CYCLES(IDLE_CYCLES),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .start(start),
        .abort(abort),
        .baud_sel(baud_sel),
        .locked(locked),
        .busy(busy),
        .done(done),
        .err(err),
        .meas_cnt(meas_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) step();
    endtask

    // Rate code for a pulse width: nearest of the five nominal bit periods,
    // -1 when shorter than half the fastest period, -2 when beyond 1.5 slowest periods.
    function automatic int ref_code(input int w);
        int per [5];
        per[0] = CLK_HZ / 9600;
        per[1] = CLK_HZ / 19200;
        per[2] = CLK_HZ / 38400;
        per[3] = CLK_HZ / 57600;
        per[4] = CLK_HZ / 115200;
        if (w > per[0] + per[0] / 2) return -2;
        for (int k = 0; k < 4; k++)
            if (w >= (per[k] + per[k+1]) / 2) return k;
        if (w >= per[4] / 2) return 4;
        return -1;
    endfunction

    task automatic model_apply(input int w, input int h);
        int c;
        c = ref_code(w);
        if (c == -2) begin
            exp_err = 1;
        end else begin
            exp_meas = w;
            if (c < 0) begin
                exp_err = 1;
            end else begin
`ifdef AUTOBAUD_VERIFY_EN
                if (ref_code(h) != c) begin
                    exp_err = 1;
                end else begin
                    exp_baud   = c;
                    exp_locked = 1;
                end
`else
                exp_baud   = c;
                exp_locked = 1;
`endif
            end
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        exp_locked = 0;
        exp_err    = 0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_locked_cleared"}, locked, 0);
        check({tag, "_err_cleared"}, err, 0);
    endtask

    task automatic do_run(input string tag, input int w, input int h, input int restart_at);
        $display("run %s low=%0d high=%0d", tag, w, h);
        done_cnt = 0;
        pulse_start(tag);
        if (restart_at > 0) begin
            hold(1'b1, restart_at);
            start = 1'b1;
            step();
            start = 1'b0;
            hold(1'b1, IDLE_WAIT - restart_at - 1);
        end else begin
            hold(1'b1, IDLE_WAIT);
        end
        hold(1'b0, w);
        hold(1'b1, h);
        hold(1'b0, 20);
        hold(1'b1, 40);
        model_apply(w, h);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_baud_sel"}, baud_sel, exp_baud);
        check({tag, "_locked"}, locked, exp_locked);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_meas_cnt"}, meas_cnt, exp_meas);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int bw [6];
        int w;
        int h;

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_baud_sel", baud_sel, 0);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_meas_cnt", meas_cnt, 0);
        rst_n = 1'b1;
        repeat (3) step();

        do_run("r434", 434, 434, 0);
        do_run("r5208", 5208, 5208, 0);
        do_run("r1302_restart", 1302, 1302, 500);

        // start and abort together in IDLE: nothing may change
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_locked", locked, exp_locked);
        step();
        check("sa_busy_later", busy, 0);
        check("sa_baud_sel", baud_sel, exp_baud);

        do_run("glitch", 100, 200, 0);

        // abort 200 cycles into the low measurement
        done_cnt = 0;
        pulse_start("abort");
        hold(1'b1, IDLE_WAIT);
        hold(1'b0, 202);
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy_after", busy, 0);
        hold(1'b0, 50);
        hold(1'b1, 40);
        check("abort_done_pulses", done_cnt, 0);
        check("abort_baud_sel", baud_sel, exp_baud);
        check("abort_locked", locked, 0);
        check("abort_err", err, 0);

        // overlong low: error must fire on the 7813th counted cycle while rx is still low
        done_cnt = 0;
        pulse_start("ovf");
        hold(1'b1, IDLE_WAIT);
        hold(1'b0, 2 + (CLK_HZ / 9600) * 3 / 2);
        check("ovf_err_early", err, 0);
        check("ovf_done_early", done_cnt, 0);
        step();
        check("ovf_err_rise", err, 1);
        check("ovf_done_rise", done, 1);
        hold(1'b0, 10000 - 3 - (CLK_HZ / 9600) * 3 / 2);
        hold(1'b1, 40);
        exp_err = 1;
        check("ovf_done_pulses", done_cnt, 1);
        check("ovf_err", err, exp_err);
        check("ovf_locked", locked, 0);
        check("ovf_baud_sel", baud_sel, exp_baud);

        bw[0] = 216;
        bw[1] = 217;
        bw[2] = 650;
        bw[3] = 651;
        bw[4] = 1084;
        bw[5] = 1085;
        for (int i = 0; i < 6; i++) do_run($sformatf("bnd%0d", bw[i]), bw[i], bw[i], 0);

        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(150, 3000);
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 3000) : w;
            do_run($sformatf("rnd%0d", i), w, h, 0);
        end

        do_run("low434_high868", 434, 868, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
